// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch/decode sequencer driving PC strobes and IR.
// Optional return-address stack (CALL/RET) is compiled in with FETCH_CTRL_CALL_EN.
module fetch_controller #(
    parameter int WORD_SIZE   = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] instr_in,
    input  logic [WORD_SIZE-1:0] pc_address,
    input  logic                 zero_flag,
    input  logic                 exec_done,
    output logic                 pc_reset,
    output logic                 pc_count_enable,
    output logic                 pc_jump_enable,
    output logic                 pc_load_address,
    output logic [WORD_SIZE-1:0] jump_address,
    output logic [WORD_SIZE-1:0] ir,
    output logic                 ir_valid,
    output logic                 halted,
    output logic                 fault,
    output logic [2:0]           state
);
    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        FETCH   = 3'd2,
        LATCH   = 3'd3,
        DECODE  = 3'd4,
        EXECUTE = 3'd5,
        ADVANCE = 3'd6,
        HALT    = 3'd7
    } state_t;

    state_t               cur, nxt;
    logic                 issued;
    logic                 do_jump;
    logic [WORD_SIZE-1:0] jump_target;
    logic [3:0]           opcode;
    logic [WORD_SIZE-1:0] ir_target;

    assign opcode    = ir[WORD_SIZE-1 -: 4];
    assign ir_target = {4'h0, ir[WORD_SIZE-5:0]};

`ifdef FETCH_CTRL_CALL_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

    logic [WORD_SIZE-1:0] stack [STACK_DEPTH];
    logic [SPW-1:0]       sp;
    logic [IW-1:0]        top_idx;
    logic                 push, pop, err, fault_r;

    assign top_idx = IW'(sp - SPW'(1));
    assign fault   = fault_r;
`else
    logic unused_cfg;
    assign unused_cfg = ^pc_address ^ STACK_DEPTH[0];
    assign fault      = 1'b0;
`endif

    always_comb begin
        nxt             = cur;
        pc_reset        = 1'b0;
        pc_count_enable = 1'b0;
        pc_jump_enable  = 1'b0;
        pc_load_address = 1'b0;
        jump_address    = '0;
        ir_valid        = 1'b0;
        do_jump         = 1'b0;
        jump_target     = ir_target;
`ifdef FETCH_CTRL_CALL_EN
        push = 1'b0;
        pop  = 1'b0;
        err  = 1'b0;
`endif
        case (cur)
            INIT: begin
                // Held in INIT while reset is high; the strobe belongs to the first free cycle.
                pc_reset = !reset;
                nxt      = IDLE;
            end
            IDLE:    if (start) nxt = FETCH;
            FETCH: begin
                pc_load_address = 1'b1;
                nxt             = LATCH;
            end
            LATCH: begin
                pc_load_address = 1'b1;
                nxt             = DECODE;
            end
            DECODE: begin
                case (opcode)
                    4'hF: nxt = HALT;
                    4'hE: do_jump = 1'b1;
                    4'hD: if (zero_flag) do_jump = 1'b1; else nxt = ADVANCE;
`ifdef FETCH_CTRL_CALL_EN
                    4'hC: begin
                        if (sp == SPW'(STACK_DEPTH)) begin
                            err = 1'b1;
                            nxt = HALT;
                        end else begin
                            push    = 1'b1;
                            do_jump = 1'b1;
                        end
                    end
                    4'hB: begin
                        if (sp == '0) begin
                            err = 1'b1;
                            nxt = HALT;
                        end else begin
                            pop         = 1'b1;
                            do_jump     = 1'b1;
                            jump_target = stack[top_idx];
                        end
                    end
`endif
                    default: nxt = EXECUTE;
                endcase
            end
            EXECUTE: begin
                ir_valid = !issued;
                if (exec_done) nxt = ADVANCE;
            end
            ADVANCE: begin
                pc_count_enable = 1'b1;
                nxt             = FETCH;
            end
            default: nxt = HALT;
        endcase
        // Jumps complete inside DECODE so a taken branch costs three cycles.
        if (do_jump) begin
            pc_jump_enable = 1'b1;
            jump_address   = jump_target;
            nxt            = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur    <= INIT;
            ir     <= '0;
            issued <= 1'b0;
`ifdef FETCH_CTRL_CALL_EN
            sp      <= '0;
            fault_r <= 1'b0;
`endif
        end else begin
            cur    <= nxt;
            issued <= (cur == EXECUTE);
            if (cur == LATCH) ir <= instr_in;
`ifdef FETCH_CTRL_CALL_EN
            if (err)  fault_r <= 1'b1;
            if (push) sp <= sp + SPW'(1);
            if (pop)  sp <= sp - SPW'(1);
`endif
        end
    end

`ifdef FETCH_CTRL_CALL_EN
    always_ff @(posedge clk) begin
        if (push) stack[IW'(sp)] <= pc_address + ONE;
    end
`endif

    assign halted = (cur == HALT);
    assign state  = cur;
endmodule
